run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter WDT_LIMIT, default 1024, STEP watchdog limit in cycles (16-bit range).
REQ-002 clk  in  1  single system clock; all flops rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command strobe.
REQ-005 cmd_op  in  2  0 STOP, 1 RUN, 2 STEP, 3 CLEAR.
REQ-006 cmd_ready  out  1  command accept; constant 1 outside reset.
REQ-007 bp_en  in  1  breakpoint enable.
REQ-008 bp_addr  in  32  breakpoint PC.
REQ-009 commit  in  1  CPU commit pulse.
REQ-010 commit_pc  in  32  PC of committing instruction.
REQ-011 commit_halt  in  1  committing instruction is halt.
REQ-012 global_en  out  1  CPU advance enable.
REQ-013 state  out  2  0 IDLE, 1 RUN, 2 STEP, 3 HALTED.
REQ-014 halt_cause  out  3  0 NONE, 1 STOP, 2 STEP_DONE, 3 BREAK, 4 HALT, 5 TIMEOUT.
REQ-015 cycle_cnt  out  32  cycles with global_en high.
REQ-016 commit_cnt  out  32  commits observed with global_en high.

Function
REQ-017 Command accepted on a rising edge where cmd_valid=1; effect visible the following cycle.
REQ-018 global_en SHALL be a decode of the state register: 1 in RUN/STEP, 0 in IDLE/HALTED, no combinational path from any input.
REQ-019 IDLE: RUN -> RUN, STEP -> STEP; both set halt_cause=NONE; STOP ignored.
REQ-020 RUN/STEP: STOP -> IDLE, cause STOP; RUN/STEP commands ignored.
REQ-021 STEP: first commit (global_en=1) -> IDLE, cause STEP_DONE.
REQ-022 RUN: commit with bp_en=1 and commit_pc==bp_addr -> IDLE, cause BREAK; the matching instruction is committed and counted.
REQ-023 RUN/STEP: commit with commit_halt=1 -> HALTED, cause HALT.
REQ-024 HALTED: only CLEAR acts; RUN, STEP, STOP ignored.
REQ-025 CLEAR from any state -> IDLE, cause NONE, both counters 0.
REQ-026 Same-edge priority: CLEAR > commit_halt > STEP_DONE/BREAK > STOP; lower events dropped, no causes queued.
REQ-027 commit in the same cycle as an accepted command is still counted unless the command is CLEAR.
REQ-028 commit while global_en=0 is not counted and does not trigger transitions.
REQ-029 Counters increment by 1 and saturate at 0xFFFFFFFF (no wrap).

Reset
REQ-030 rst low asynchronously forces state=IDLE, global_en=0, halt_cause=NONE, counters=0, watchdog=0, cmd_ready=0.
REQ-031 Reset mid-RUN/STEP drops global_en immediately, without waiting for clk.
REQ-032 First command accepted on the first rising edge after rst deasserts.

Configuration
REQ-033 Macro RUN_CTRL_WDT_EN defined: 16-bit watchdog clears on STEP entry, increments each STEP cycle without commit; reaching WDT_LIMIT -> IDLE, cause TIMEOUT; a commit on the limit cycle wins (STEP_DONE).
REQ-034 Macro undefined: no watchdog logic; STEP waits indefinitely; cause 5 never produced.

Verification
REQ-035 Reset, RUN, commits at 0x00,0x04,0x08; bp_en=1, bp_addr=0x08 -> IDLE, cause 3, commit_cnt=3, global_en low the cycle after 0x08 commit.
REQ-036 STEP from IDLE, commit after 2 cycles -> IDLE, cause 2, commit_cnt=1, cycle_cnt=3.
REQ-037 RUN, commit with commit_halt=1 and simultaneous STOP -> HALTED, cause 4; then RUN -> still HALTED; CLEAR -> IDLE, counters 0.
REQ-038 With RUN_CTRL_WDT_EN, WDT_LIMIT=8, STEP without commit -> IDLE, cause 5 after 8 cycles; without macro -> remains STEP.
REQ-039 cycle_cnt preloaded near 0xFFFFFFFF by RUN for 2^32+3 cycles (force) -> holds 0xFFFFFFFF.
REQ-040 rst low mid-RUN, between clk edges -> global_en=0 and state=0 before next edge.

Source files
------------

// File: rtl/run_ctrl.sv
// Debug run controller: gates CPU advance through RUN/STEP/HALTED states and counts enabled cycles and commits.
// Optional STEP watchdog (limit WDT_LIMIT cycles) is built only when RUN_CTRL_WDT_EN is defined.
module run_ctrl #(
    parameter int unsigned WDT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic        commit,
    input  logic [31:0] commit_pc,
    input  logic        commit_halt,
    output logic        global_en,
    output logic [1:0]  state,
    output logic [2:0]  halt_cause,
    output logic [31:0] cycle_cnt,
    output logic [31:0] commit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_STEP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [2:0] C_NONE    = 3'd0;
    localparam logic [2:0] C_STOP    = 3'd1;
    localparam logic [2:0] C_STEP    = 3'd2;
    localparam logic [2:0] C_BREAK   = 3'd3;
    localparam logic [2:0] C_HALT    = 3'd4;
    localparam logic [2:0] C_TIMEOUT = 3'd5;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t state_q;

    logic cmd_clear;
    logic run_commit;
    logic hit_halt;
    logic hit_step;
    logic hit_bp;
    logic hit_stop;
    logic hit_wdt;

    // Reset low holds the port not-ready; outside reset every command is taken.
    assign cmd_ready = rst;
    assign state     = state_q;
    assign global_en = (state_q == S_RUN) || (state_q == S_STEP);

    assign cmd_clear  = cmd_valid && (cmd_op == OP_CLEAR);
    assign run_commit = global_en && commit;
    assign hit_halt   = run_commit && commit_halt;
    assign hit_step   = run_commit && (state_q == S_STEP);
    assign hit_bp     = run_commit && (state_q == S_RUN) && bp_en && (commit_pc == bp_addr);
    assign hit_stop   = global_en && cmd_valid && (cmd_op == OP_STOP);

`ifdef RUN_CTRL_WDT_EN
    logic [15:0] wdt_q;
    logic [16:0] wdt_inc;

    assign wdt_inc = {1'b0, wdt_q} + 17'd1;
    assign hit_wdt = (state_q == S_STEP) && !commit && (wdt_inc == 17'(WDT_LIMIT));
`else
    logic [15:0] wdt_limit_unused;

    assign wdt_limit_unused = 16'(WDT_LIMIT);
    assign hit_wdt          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            halt_cause <= C_NONE;
            cycle_cnt  <= '0;
            commit_cnt <= '0;
`ifdef RUN_CTRL_WDT_EN
            wdt_q      <= '0;
`endif
        end else if (cmd_clear) begin
            state_q    <= S_IDLE;
            halt_cause <= C_NONE;
            cycle_cnt  <= '0;
            commit_cnt <= '0;
`ifdef RUN_CTRL_WDT_EN
            wdt_q      <= '0;
`endif
        end else begin
            if (global_en) cycle_cnt <= sat_inc(cycle_cnt);
            if (run_commit) commit_cnt <= sat_inc(commit_cnt);

            // One winner per edge; lower-priority events are dropped, not queued.
            if (hit_halt) begin
                state_q    <= S_HALTED;
                halt_cause <= C_HALT;
            end else if (hit_step) begin
                state_q    <= S_IDLE;
                halt_cause <= C_STEP;
            end else if (hit_bp) begin
                state_q    <= S_IDLE;
                halt_cause <= C_BREAK;
            end else if (hit_stop) begin
                state_q    <= S_IDLE;
                halt_cause <= C_STOP;
            end else if (hit_wdt) begin
                state_q    <= S_IDLE;
                halt_cause <= C_TIMEOUT;
            end else if ((state_q == S_IDLE) && cmd_valid && (cmd_op == OP_RUN)) begin
                state_q    <= S_RUN;
                halt_cause <= C_NONE;
            end else if ((state_q == S_IDLE) && cmd_valid && (cmd_op == OP_STEP)) begin
                state_q    <= S_STEP;
                halt_cause <= C_NONE;
            end

`ifdef RUN_CTRL_WDT_EN
            // Counts only idle STEP cycles; any other cycle restarts it, so STEP entry sees zero.
            if ((state_q == S_STEP) && !commit) wdt_q <= wdt_inc[15:0];
            else wdt_q <= '0;
`endif
        end
    end

endmodule
